// File: rtl/clk_div_sched_pkg.sv
// clk_div_sched_pkg: shared definitions for the clock-divider scheduler.
//   - SEL_* : ratio select encodings (same as the lab divider datapath)
//   - req_state_e : request handshake FSM states
//   - div_of() : maps a ratio select onto the configured divide ratio
package clk_div_sched_pkg;

  localparam logic [1:0] SEL_DIV3 = 2'b00;
  localparam logic [1:0] SEL_DIV2 = 2'b01;
  localparam logic [1:0] SEL_DIV4 = 2'b10;
  localparam logic [1:0] SEL_DIV8 = 2'b11;

  typedef enum logic {
    RUN,
    PEND
  } req_state_e;

  // Ratios are module parameters, so the caller passes them in.
  function automatic int unsigned div_of(input logic [1:0]  sel,
                                         input int unsigned d0,
                                         input int unsigned d1,
                                         input int unsigned d2,
                                         input int unsigned d3);
    int unsigned n;
    case (sel)
      SEL_DIV3: n = d0;
      SEL_DIV2: n = d1;
      SEL_DIV4: n = d2;
      default:  n = d3;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/clk_div_sched_cnt.sv
// clk_div_sched_cnt: period counter for the clock-divider scheduler.
// Counts 0..N-1 and wraps; tick is registered, high for the cycle after a wrap edge.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_load_zero     force the counter to 0 on the next edge (ratio switch)
//   i_div           divide ratio N (CNT_W+1 bits so N = 2^CNT_W fits)
//   o_wrap          combinational: counter is at N-1 this cycle
//   o_tick          registered one-cycle enable pulse, once per period
//   o_phase         current counter value
module clk_div_sched_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load_zero,
  input  logic [CNT_W:0]   i_div,
  output logic             o_wrap,
  output logic             o_tick,
  output logic [CNT_W-1:0] o_phase
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic [CNT_W:0]   w_div_m1;

  assign w_div_m1 = i_div - (CNT_W + 1)'(1);
  assign o_wrap   = ({1'b0, r_cnt} == w_div_m1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      if (i_load_zero || o_wrap) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_tick <= o_wrap;
    end
  end

  assign o_tick  = r_tick;
  assign o_phase = r_cnt;

endmodule

// File: rtl/clk_div_sched.sv
// clk_div_sched: clock-enable tick generator with boundary-aligned ratio switching.
// A ratio request is accepted through a valid/ready port and applied only at a
// period wrap, so no period downstream is ever truncated or stretched.
// Optional build macro CLK_DIV_SCHED_TICK_CNT_EN adds o_tick_cnt (16-bit tick counter).
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_req_valid/i_req_sel, o_req_ready   ratio request handshake
//   o_req_ack           one-cycle pulse when the pending request takes effect
//   o_cur_sel           ratio select currently in force
//   o_tick              one-cycle enable pulse per period
//   o_phase             period counter value
//   o_tick_cnt          (macro only) ticks since reset / last ack, wraps at 16 bits
module clk_div_sched
  import clk_div_sched_pkg::*;
#(
  parameter int unsigned DIV0      = 3,
  parameter int unsigned DIV1      = 2,
  parameter int unsigned DIV2      = 4,
  parameter int unsigned DIV3      = 8,
  parameter int unsigned CNT_W     = 4,
  parameter logic [1:0]  RESET_SEL = 2'b01
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_valid,
  input  logic [1:0]       i_req_sel,
  output logic             o_req_ready,
  output logic             o_req_ack,
  output logic [1:0]       o_cur_sel,
`ifdef CLK_DIV_SCHED_TICK_CNT_EN
  output logic [15:0]      o_tick_cnt,
`endif
  output logic             o_tick,
  output logic [CNT_W-1:0] o_phase
);

  req_state_e     r_state, w_state_next;
  logic [1:0]     r_cur_sel, r_pend_sel;
  logic [1:0]     w_cur_sel_next, w_pend_sel_next;
  logic           r_ack;
  logic           w_apply;
  logic           w_wrap;
  logic           w_tick;
  logic [CNT_W:0] w_div;

  assign w_div = (CNT_W + 1)'(div_of(r_cur_sel, DIV0, DIV1, DIV2, DIV3));

  clk_div_sched_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_load_zero (w_apply),
    .i_div       (w_div),
    .o_wrap      (w_wrap),
    .o_tick      (w_tick),
    .o_phase     (o_phase)
  );

  always_comb begin
    w_state_next    = r_state;
    w_cur_sel_next  = r_cur_sel;
    w_pend_sel_next = r_pend_sel;
    w_apply         = 1'b0;
    o_req_ready     = 1'b0;
    unique case (r_state)
      RUN: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          w_pend_sel_next = i_req_sel;
          if (w_wrap) begin
            // Request lands on a boundary: switch now, no PEND detour.
            w_apply        = 1'b1;
            w_cur_sel_next = i_req_sel;
          end else begin
            w_state_next = PEND;
          end
        end
      end
      PEND: begin
        if (w_wrap) begin
          w_apply        = 1'b1;
          w_cur_sel_next = r_pend_sel;
          w_state_next   = RUN;
        end
      end
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= RUN;
      r_cur_sel  <= RESET_SEL;
      r_pend_sel <= 2'b00;
      r_ack      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cur_sel  <= w_cur_sel_next;
      r_pend_sel <= w_pend_sel_next;
      r_ack      <= w_apply;
    end
  end

`ifdef CLK_DIV_SCHED_TICK_CNT_EN
  logic [15:0] r_tick_cnt;

  // Ack clears with priority; the tick coinciding with the ack closes the old ratio.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick_cnt <= 16'd0;
    end else if (r_ack) begin
      r_tick_cnt <= 16'd0;
    end else if (w_tick) begin
      r_tick_cnt <= r_tick_cnt + 16'd1;
    end
  end

  assign o_tick_cnt = r_tick_cnt;
`endif

  assign o_req_ack = r_ack;
  assign o_cur_sel = r_cur_sel;
  assign o_tick    = w_tick;

endmodule

// File: tb/tb_clk_div_sched.sv
module tb_clk_div_sched;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [1:0] req_sel;
  logic       req_ready;
  logic       req_ack;
  logic [1:0] cur_sel;
  logic       tick;
  logic [3:0] phase;
`ifdef CLK_DIV_SCHED_TICK_CNT_EN
  logic [15:0] tick_cnt;
`endif

  clk_div_sched dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_sel   (req_sel),
    .o_req_ready (req_ready),
    .o_req_ack   (req_ack),
    .o_cur_sel   (cur_sel),
`ifdef CLK_DIV_SCHED_TICK_CNT_EN
    .o_tick_cnt  (tick_cnt),
`endif
    .o_tick      (tick),
    .o_phase     (phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_acks   = 0;
  bit         mon_en   = 1'b0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned div_n(input logic [1:0] s);
    case (s)
      2'b00:   return 3;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 8;
    endcase
  endfunction

  // Scoreboard monitor: checks tick spacing against the model ratio, and pops
  // the expected select on every ack.
  initial begin
    int         cyc;
    int         last;
    bit         have_last;
    logic [1:0] m_sel;
    logic [1:0] s;
    cyc = 0; last = 0; have_last = 1'b0; m_sel = 2'b01;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        cyc = 0; have_last = 1'b0; m_sel = 2'b01;
        exp_q.delete();
      end else begin
        cyc++;
        if (tick) begin
          if (have_last) check("tick_gap", cyc - last, div_n(m_sel));
          last = cyc;
          have_last = 1'b1;
        end
        if (req_ack) begin
          n_acks++;
          if (exp_q.size() == 0) begin
            check("ack_unexpected", 1, 0);
          end else begin
            s = exp_q.pop_front();
            check("ack_sel", cur_sel, s);
            m_sel = s;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en    = 1'b0;
    req_valid = 1'b0;
    req_sel   = 2'b00;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic wait_phase(input int unsigned p);
    for (int i = 0; i < 20; i++) begin
      if (phase == p) return;
      step();
    end
    check("phase_timeout", phase, p);
  endtask

  task automatic wait_ack(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (req_ack) return;
    end
    check("ack_timeout", 0, 1);
  endtask

  // Drive one request for one cycle; returns #1 after the sampling edge.
  task automatic send(input logic [1:0] s, input bit push);
    check("ready_on_send", req_ready, 1);
    req_valid = 1'b1;
    req_sel   = s;
    if (push) exp_q.push_back(s);
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    int ack_base;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_sel   = 2'b00;

    // Reset state and free-running /2
    repeat (2) @(posedge clk);
    #1;
    check("rst_phase", phase, 0);
    check("rst_cur_sel", cur_sel, 1);
    check("rst_tick", tick, 0);
    check("rst_ack", req_ack, 0);
    check("rst_ready", req_ready, 1);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("div2_phase", phase, k % 2);
      check("div2_tick", tick, (k % 2 == 0) ? 1 : 0);
      check("div2_ready", req_ready, 1);
    end

    // Request /8 at phase 0 under /2
    wait_phase(0);
    send(2'b11, 1'b1);
    check("pend_ready_low", req_ready, 0);
    wait_ack(4);
    check("sw8_cur_sel", cur_sel, 3);
    repeat (30) step();

    // Request /3 on the same cycle as a /4 wrap
    do_reset();
    wait_phase(0);
    send(2'b10, 1'b1);
    wait_ack(4);
    wait_phase(3);
    send(2'b00, 1'b1);
    check("imm_ack", req_ack, 1);
    check("imm_ready", req_ready, 1);
    check("imm_phase", phase, 0);
    check("imm_cur_sel", cur_sel, 0);
    check("imm_tick_old", tick, 1);
    step();
    check("imm_tick_e1", tick, 0);
    step();
    check("imm_tick_e2", tick, 0);
    step();
    check("imm_tick_e3", tick, 1);
    repeat (12) step();

    // Second request while pending is ignored
    do_reset();
    wait_phase(0);
    ack_base = n_acks;
    send(2'b10, 1'b1);
    check("pend2_ready_low", req_ready, 0);
    req_valid = 1'b1;
    req_sel   = 2'b11;
    step();
    req_valid = 1'b0;
    check("pend2_ack", req_ack, 1);
    check("pend2_cur_sel", cur_sel, 2);
    repeat (20) step();
    check("pend2_cur_sel_hold", cur_sel, 2);
    check("pend2_ack_count", n_acks - ack_base, 1);

    // Same-ratio request still waits and acks
    do_reset();
    wait_phase(0);
    send(2'b01, 1'b1);
    wait_ack(4);
    check("same_cur_sel", cur_sel, 1);
    repeat (10) step();

    // Reset pulse while a request is pending
    do_reset();
    wait_phase(0);
    send(2'b10, 1'b1);
    wait_ack(4);
    wait_phase(1);
    send(2'b11, 1'b0);
    check("rstp_ready_low", req_ready, 0);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("rstp_cur_sel", cur_sel, 1);
    check("rstp_tick", tick, 0);
    check("rstp_phase", phase, 0);
    check("rstp_ack", req_ack, 0);
    check("rstp_ready", req_ready, 1);
`ifdef CLK_DIV_SCHED_TICK_CNT_EN
    check("rstp_tick_cnt", tick_cnt, 0);
`endif
    step();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (10) step();
    check("rstp_cur_sel_after", cur_sel, 1);

    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
- Controller for the lab clock-divider datapath. It produces a one-cycle clock-enable tick at a selectable divide ratio (÷3/÷2/÷4/÷8, same sel encoding as the divider).
- Divide-ratio changes arrive through a valid/ready request port. A change is applied only at a period boundary, so downstream logic never sees a truncated or stretched period.
- Sits between the top-level switch/FSM logic and the tick-enabled counters and display logic.

Parameters:
- DIV0, 3, divide ratio for sel=2'b00
- DIV1, 2, divide ratio for sel=2'b01
- DIV2, 4, divide ratio for sel=2'b10
- DIV3, 8, divide ratio for sel=2'b11
- CNT_W, 4, period counter width; every DIVn must satisfy 2 <= DIVn <= 2^CNT_W
- RESET_SEL, 2'b01, ratio select loaded at reset

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  new ratio request
- req_sel  in  2  requested ratio select
- req_ready  out  1  request can be accepted (no request pending)
- req_ack  out  1  one-cycle pulse: pending request has taken effect
- cur_sel  out  2  ratio select currently in force
- tick  out  1  one-cycle enable pulse, once per period
- phase  out  CNT_W  current period counter value

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: cnt/phase=0, cur_sel=RESET_SEL, tick=0, req_ack=0, req_ready=1.
  - Internal pending flag cleared. Pending latch pend_sel=0.
- Period counter:
  - N = DIV[cur_sel]. cnt counts 0..N-1 and wraps to 0.
  - wrap = (cnt == N-1).
  - tick is registered: tick=1 for exactly the cycle after the clock edge at which wrap was true. Its period is exactly N cycles.
- Request FSM, states RUN and PEND:
  - RUN: req_ready=1. If req_valid=1, latch pend_sel=req_sel.
    - No wrap this cycle: go to PEND.
    - Wrap this cycle: apply immediately. cur_sel<=req_sel, cnt<=0, req_ack<=1 next cycle, stay in RUN.
  - PEND: req_ready=0 and req_valid is ignored. On wrap: cur_sel<=pend_sel, cnt<=0, req_ack<=1 (one cycle), go to RUN.
- The request that produced an ack is the only one applied. Requests are never queued beyond one.
- A request for the ratio already in force still waits for the wrap and still acks. Period length is unchanged.
- The period after a switch uses the new N. The tick emitted for the completing period is unaffected.
- Reset asserted mid-PEND: the pending request is discarded, no ack is issued, and cur_sel returns to RESET_SEL.
- Out-of-range phase is impossible because cnt is cleared at every switch.

Optional Feature:
- Macro: CLK_DIV_SCHED_TICK_CNT_EN.
- Defined: adds output tick_cnt (16 bits).
  - Increments on each tick and wraps 0xFFFF->0.
  - Cleared to 0 by reset and on every req_ack cycle.
- Undefined: the port and logic are absent. All other behaviour is identical.

Decomposition:
- Package clk_div_sched_pkg holds:
  - sel encoding constants SEL_DIV3=2'b00, SEL_DIV2=2'b01, SEL_DIV4=2'b10, SEL_DIV8=2'b11
  - FSM state typedef (RUN, PEND)
  - div_of(sel) function returning N from the parameters
- One sub-module, clk_div_sched_cnt: period counter with load-zero input, N input, wrap and registered tick outputs.
- The FSM and handshake logic stay in the top module.

Test Plan:
- Reset release with RESET_SEL=01, no requests: tick high after edges 2, 4, 6…; phase alternates 1,0; req_ready=1 throughout.
- Request req_sel=11 at phase=0 under ÷2:
  - req_ready falls next cycle.
  - Switch at the next wrap; req_ack pulses once.
  - Subsequent ticks are exactly 8 cycles apart; cur_sel=11.
- Request req_sel=00 presented in the same cycle as a ÷4 wrap: immediate switch, req_ack next cycle, next tick 3 cycles after the switch edge, req_ready stays 1.
- Second req_valid while in PEND (first req 10, second 11): second is ignored; cur_sel becomes 10; exactly one req_ack.
- Same-ratio request (req_sel=01 under ÷2): ack at the next wrap; tick spacing remains 2 throughout.
- rst pulsed low while in PEND (request 11 pending under ÷4 at phase=1): no req_ack; cur_sel=01, tick=0, phase=0 immediately; with the macro defined, tick_cnt=0.
